ldst_unit: RTL and testbench
============================

# ldst_unit

Load/store stage sitting directly downstream of the CPU's decode/execute logic and upstream of the synchronous data memory. It accepts one ARM single-data-transfer request (LDR/STR word, immediate offset) per handshake. It computes the effective byte address and drives the memory's registered read/write port. It then returns load data and an optional base-register writeback value to the register-file write stage.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width.
- DATA_WORDS, 32, words in data memory; word address width is $clog2(DATA_WORDS).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE and reset deasserted.
- req_load  in  1  1 = LDR, 0 = STR (instruction L bit).
- req_up  in  1  1 = add offset, 0 = subtract (U bit).
- req_pre  in  1  1 = pre-index, 0 = post-index (P bit).
- req_wb  in  1  base writeback requested (W bit).
- req_base  in  32  Rn value.
- req_offset  in  12  unsigned immediate offset.
- req_store_data  in  DATA_WIDTH  Rd value for stores.
- req_rd  in  4  destination/source register index.
- req_rn  in  4  base register index.
- mem_addr  out  $clog2(DATA_WORDS)  registered word address.
- mem_we  out  1  registered write enable.
- mem_wd  out  DATA_WIDTH  registered write data.
- mem_rd  in  DATA_WIDTH  memory read data, valid one edge after mem_addr.
- resp_valid  out  1  completion present.
- resp_ready  in  1  consumer accepts completion.
- resp_load  out  1  completion is a load (resp_data valid).
- resp_rd  out  4  register for resp_data.
- resp_data  out  DATA_WIDTH  loaded word.
- resp_fault  out  1  misaligned access; no memory write, no writeback.
- wb_valid  out  1  base writeback present, qualified by resp_valid.
- wb_rn  out  4  base register index.
- wb_data  out  32  updated base.

## Operation
- Offset zero-extended to 32 bits; new_base = req_base ± offset mod 2^32.
- Effective address: new_base if req_pre, else req_base.
- mem_addr = address[$clog2(DATA_WORDS)+1:2]; upper bits ignored, so addresses wrap modulo memory size.
- Fault when address[1:0] != 0. A faulting request performs no write, returns resp_fault=1, and sets wb_valid=0.
- Writeback: wb_valid=1 when !fault and (!req_pre or req_wb); wb_data=new_base. When rn == rd on a load, the consumer applies resp_data last; the unit reports both unchanged.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch the request, register mem_addr/mem_wd, set mem_we=store&!fault, go ACCESS.
  - ACCESS: mem_we is high this cycle only. Load&!fault goes to WAIT; otherwise go to RESP.
  - WAIT: capture mem_rd into resp_data; go RESP.
  - RESP: resp_valid=1, all resp/wb outputs stable. On resp_ready go IDLE. No new request is accepted in the same cycle.
- Reset values: state IDLE, req_ready 0 while reset is high, mem_we 0, mem_addr 0, mem_wd 0, resp_valid 0, resp_* 0, wb_valid 0, wb_rn 0, wb_data 0.
- Reset asserted mid-operation: immediate return to IDLE. A store whose mem_we has not yet been sampled by memory is dropped. No response is issued.

## Timing
- Accept at edge E0.
- Store: memory writes at E1; resp_valid from E1.
- Load: memory reads at E1; resp_data captured at E2; resp_valid from E2.
- Fault: resp_valid from E1.
- Throughput: one request per 3 cycles (store) or 4 cycles (load), with resp_ready held high.
- mem_we is never high for more than one cycle per request.

## Configuration
- LDST_WRITEBACK_EN defined:
  - P and W bits are honoured as above.
- LDST_WRITEBACK_EN undefined:
  - req_pre and req_wb are ignored; the address is always req_base ± offset.
  - wb_valid is tied 0, wb_rn and wb_data are tied 0, and the writeback adder path is removed.

## Structure
- ldst_pkg: FSM state enum (IDLE, ACCESS, WAIT, RESP), request struct typedef, and the offset width constant (12).
- Sub-module ldst_addr_gen: combinational new_base, effective address, word address, and fault computation. Instantiated once.

## Test plan
- LDR, base 0x10, offset 4, up, pre, no W; mem word 5 = 0xDEADBEEF -> mem_addr=5 at E0+; resp_valid at E2, resp_data=0xDEADBEEF, wb_valid=0.
- STR, base 0x20, offset 8, down, pre, W, data 0x1234 -> mem_we one cycle, mem_addr=6, mem_wd=0x1234; resp at E1; wb_valid=1, wb_data=0x18.
- LDR post-index, base 0x7C, offset 4 -> read from word 31; wb_data=0x80. Next LDR at 0x80 wraps to word 0.
- STR, base 0x22 -> resp_fault=1, mem_we never asserted, wb_valid=0.
- Load with resp_ready held low 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout; first resp_ready returns to IDLE.
- Reset pulse in ACCESS of a store -> mem_we=0 immediately, state IDLE, no resp_valid. Build without LDST_WRITEBACK_EN -> wb_valid always 0.

Source files
------------

// File: rtl/ldst_pkg.sv
// ldst_pkg: shared types for the load/store unit.
//   ldst_state_e : sequencing states (IDLE, ACCESS, WAIT, RESP)
//   ldst_req_t   : request fields held while a transfer is in flight
//   OFFSET_W     : width of the unsigned immediate offset
package ldst_pkg;

    localparam int OFFSET_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } ldst_state_e;

    typedef struct packed {
        logic        load;
        logic        fault;
        logic        wb_valid;
        logic [3:0]  rd;
        logic [3:0]  wb_rn;
        logic [31:0] wb_data;
    } ldst_req_t;

endpackage

// File: rtl/ldst_unit_if.sv
// ldst_unit_if: request, memory-port and response signals of the load/store unit.
//   slave  : the load/store unit side
//   master : the environment side (execute stage, data memory, writeback stage)
interface ldst_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_WORDS = 32
);
    import ldst_pkg::*;

    localparam int AW = $clog2(DATA_WORDS);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_load;
    logic                  req_up;
    logic                  req_pre;
    logic                  req_wb;
    logic [31:0]           req_base;
    logic [OFFSET_W-1:0]   req_offset;
    logic [DATA_WIDTH-1:0] req_store_data;
    logic [3:0]            req_rd;
    logic [3:0]            req_rn;

    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_load;
    logic [3:0]            resp_rd;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_fault;
    logic                  wb_valid;
    logic [3:0]            wb_rn;
    logic [31:0]           wb_data;

    modport slave (
        input  req_valid, req_load, req_up, req_pre, req_wb, req_base, req_offset,
               req_store_data, req_rd, req_rn, mem_rd, resp_ready,
        output req_ready, mem_addr, mem_we, mem_wd, resp_valid, resp_load, resp_rd,
               resp_data, resp_fault, wb_valid, wb_rn, wb_data
    );

    modport master (
        output req_valid, req_load, req_up, req_pre, req_wb, req_base, req_offset,
               req_store_data, req_rd, req_rn, mem_rd, resp_ready,
        input  req_ready, mem_addr, mem_we, mem_wd, resp_valid, resp_load, resp_rd,
               resp_data, resp_fault, wb_valid, wb_rn, wb_data
    );

endinterface

// File: rtl/ldst_addr_gen.sv
// ldst_addr_gen: combinational address path of the load/store unit.
//   base_i, offset_i, up_i, pre_i : base register, immediate, U bit, P bit
//   new_base_o  : base +/- zero-extended offset (mod 2^32)
//   word_addr_o : word index into data memory (upper address bits dropped, so it wraps)
//   fault_o     : effective address not word aligned
// Macro LDST_WRITEBACK_EN: when undefined the P bit is ignored and the
// effective address is always the updated base.
module ldst_addr_gen
    import ldst_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [31:0]         base_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                up_i,
    input  logic                pre_i,
    output logic [31:0]         new_base_o,
    output logic [AW-1:0]       word_addr_o,
    output logic                fault_o
);
    logic [31:0] offset_ext;
    logic [31:0] eff_addr;
    logic        unused_hi;

    assign offset_ext = {{(32-OFFSET_W){1'b0}}, offset_i};
    assign new_base_o = up_i ? (base_i + offset_ext) : (base_i - offset_ext);

`ifdef LDST_WRITEBACK_EN
    assign eff_addr = pre_i ? new_base_o : base_i;
`else
    logic unused_pre;
    assign unused_pre = pre_i;
    assign eff_addr   = new_base_o;
`endif

    assign word_addr_o = eff_addr[AW+1:2];
    assign fault_o     = |eff_addr[1:0];
    // Address bits above the memory size are deliberately discarded.
    assign unused_hi   = ^eff_addr[31:AW+2];

endmodule

// File: rtl/ldst_unit.sv
// ldst_unit: single-data-transfer (LDR/STR word, immediate offset) load/store stage.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : ldst_unit_if.slave -- request handshake, registered memory port
//           (mem_addr/mem_we/mem_wd, mem_rd one edge later), response and
//           base-writeback outputs
// Macro LDST_WRITEBACK_EN: enables P/W handling and the base writeback outputs;
// when undefined wb_valid/wb_rn/wb_data are tied to zero.
//
// state  | meaning
// IDLE   | ready for a request; memory port registered on accept
// ACCESS | memory samples the port (mem_we high only here)
// WAIT   | load data returns from memory and is captured
// RESP   | response held until resp_ready
module ldst_unit
    import ldst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_WORDS = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ldst_unit_if.slave bus
);
    localparam int AW = $clog2(DATA_WORDS);

    ldst_state_e           state_q, state_d;
    ldst_req_t             req_q, req_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [31:0]           new_base;
    logic [AW-1:0]         word_addr;
    logic                  fault;
    logic                  wb_req;
    logic [3:0]            wb_rn_in;
    logic [31:0]           wb_base;

    ldst_addr_gen #(.AW(AW)) u_addr_gen (
        .base_i      (bus.req_base),
        .offset_i    (bus.req_offset),
        .up_i        (bus.req_up),
        .pre_i       (bus.req_pre),
        .new_base_o  (new_base),
        .word_addr_o (word_addr),
        .fault_o     (fault)
    );

`ifdef LDST_WRITEBACK_EN
    assign wb_req   = !fault && (!bus.req_pre || bus.req_wb);
    assign wb_rn_in = bus.req_rn;
    assign wb_base  = new_base;
`else
    logic unused_wb;
    assign unused_wb = bus.req_wb ^ (^new_base) ^ (^bus.req_rn);
    assign wb_req    = 1'b0;
    assign wb_rn_in  = 4'd0;
    assign wb_base   = 32'd0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wd_q    <= mem_wd_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wd_d    = mem_wd_q;
        resp_data_d = resp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.load     = bus.req_load;
                    req_d.fault    = fault;
                    req_d.wb_valid = wb_req;
                    req_d.rd       = bus.req_rd;
                    req_d.wb_rn    = wb_rn_in;
                    req_d.wb_data  = wb_base;
                    mem_addr_d     = word_addr;
                    mem_wd_d       = bus.req_store_data;
                    mem_we_d       = !bus.req_load && !fault;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                state_d = (req_q.load && !req_q.fault) ? WAIT : RESP;
            end
            WAIT: begin
                resp_data_d = bus.mem_rd;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE) && !rst_i;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wd     = mem_wd_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_load  = req_q.load;
    assign bus.resp_rd    = req_q.rd;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_fault = req_q.fault;
    assign bus.wb_valid   = req_q.wb_valid;
    assign bus.wb_rn      = req_q.wb_rn;
    assign bus.wb_data    = req_q.wb_data;

endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: directed vector bench for ldst_unit with a registered-read
// data memory model; expectations cover both LDST_WRITEBACK_EN builds.
module tb_ldst_unit;
    localparam int DW     = 32;
    localparam int DWORDS = 32;
`ifdef LDST_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef struct {
        logic        load, up, pre, wb;
        logic [31:0] base;
        logic [11:0] offset;
        logic [31:0] sdata;
        logic [3:0]  rd, rn;
        logic [4:0]  word_en, word_dis;
        logic        fault, wbv_en;
        logic [31:0] nb, data_en, data_dis;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_init;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [31:0] mem [DWORDS];
    vec_t        vecs [13];

    ldst_unit_if #(.DATA_WIDTH(DW), .DATA_WORDS(DWORDS)) bus ();

    ldst_unit #(.DATA_WIDTH(DW), .DATA_WORDS(DWORDS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DWORDS; i++) mem[i] <= init_word(i);
            bus.mem_rd <= '0;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;
            bus.mem_rd <= mem[bus.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_valid      = 1'b1;
        bus.req_load       = v.load;
        bus.req_up         = v.up;
        bus.req_pre        = v.pre;
        bus.req_wb         = v.wb;
        bus.req_base       = v.base;
        bus.req_offset     = v.offset;
        bus.req_store_data = v.sdata;
        bus.req_rd         = v.rd;
        bus.req_rn         = v.rn;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!bus.resp_valid && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int         cyc;
        int         we0;
        logic [4:0] ew;
        logic       exp_we;
        ew     = WB_EN ? v.word_en : v.word_dis;
        exp_we = !v.load && !v.fault;
        @(negedge clk);
        drive_req(v);
        we0 = we_cnt;
        chk({nm, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(ew));
        chk({nm, " mem_we"}, 32'(bus.mem_we), 32'(exp_we));
        if (exp_we) chk({nm, " mem_wd"}, bus.mem_wd, v.sdata);
        wait_resp(cyc);
        chk({nm, " latency"}, 32'(cyc), (v.load && !v.fault) ? 32'd2 : 32'd1);
        chk({nm, " resp_load"}, 32'(bus.resp_load), 32'(v.load));
        chk({nm, " resp_rd"}, 32'(bus.resp_rd), 32'(v.rd));
        chk({nm, " resp_fault"}, 32'(bus.resp_fault), 32'(v.fault));
        chk({nm, " wb_valid"}, 32'(bus.wb_valid), WB_EN ? 32'(v.wbv_en) : 32'd0);
        chk({nm, " wb_rn"}, 32'(bus.wb_rn), WB_EN ? 32'(v.rn) : 32'd0);
        chk({nm, " wb_data"}, bus.wb_data, WB_EN ? v.nb : 32'd0);
        if (v.load && !v.fault)
            chk({nm, " resp_data"}, bus.resp_data, WB_EN ? v.data_en : v.data_dis);
        chk({nm, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({nm, " resp_valid done"}, 32'(bus.resp_valid), 32'd0);
        chk({nm, " req_ready done"}, 32'(bus.req_ready), 32'd1);
        chk({nm, " mem_we count"}, 32'(we_cnt - we0), 32'(exp_we));
    endtask

    initial begin
        int   cyc;
        int   we0;
        vec_t bp;
        // load up pre wb | base offset sdata | rd rn | word_en word_dis | fault wbv_en | nb data_en data_dis
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b0, 32'h10, 12'd4, 32'h0, 4'd1, 4'd2, 5'd5, 5'd5, 1'b0,1'b0, 32'h14, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1, 32'h20, 12'd8, 32'h1234, 4'd3, 4'd4, 5'd6, 5'd6, 1'b0,1'b1, 32'h18, 32'h0, 32'h0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 32'h7C, 12'd4, 32'h0, 4'd5, 4'd6, 5'd31, 5'd0, 1'b0,1'b1, 32'h80, 32'hC0DE001F, 32'hC0DE0000};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0, 32'h80, 12'd0, 32'h0, 4'd7, 4'd7, 5'd0, 5'd0, 1'b0,1'b0, 32'h80, 32'hC0DE0000, 32'hC0DE0000};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0, 32'h10, 12'd8, 32'h0, 4'd8, 4'd9, 5'd6, 5'd6, 1'b0,1'b0, 32'h18, 32'h1234, 32'h1234};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b1, 32'h22, 12'd0, 32'hBAD, 4'd2, 4'd3, 5'd8, 5'd8, 1'b1,1'b0, 32'h22, 32'h0, 32'h0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0, 32'h100, 12'd1, 32'h0, 4'd4, 4'd5, 5'd0, 5'd0, 1'b1,1'b0, 32'h101, 32'h0, 32'h0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0, 32'h40, 12'h10, 32'hCAFEF00D, 4'd6, 4'd10, 5'd16, 5'd12, 1'b0,1'b1, 32'h30, 32'h0, 32'h0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0, 32'h40, 12'd0, 32'h0, 4'd11, 4'd12, 5'd16, 5'd16, 1'b0,1'b0, 32'h40, 32'hCAFEF00D, 32'hC0DE0010};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b0, 32'hFFFFFFFC, 12'd8, 32'h0, 4'd13, 4'd14, 5'd1, 5'd1, 1'b0,1'b0, 32'h4, 32'hC0DE0001, 32'hC0DE0001};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1, 32'h4, 12'd8, 32'h55AA, 4'd1, 4'd15, 5'd31, 5'd31, 1'b0,1'b1, 32'hFFFFFFFC, 32'h0, 32'h0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1, 32'h7C, 12'h100, 32'h0, 4'd9, 4'd9, 5'd31, 5'd31, 1'b0,1'b1, 32'h17C, 32'h55AA, 32'h55AA};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0, 32'h50, 12'd0, 32'h0, 4'd2, 4'd2, 5'd20, 5'd20, 1'b0,1'b0, 32'h50, 32'hC0DE0014, 32'hC0DE0014};

        rst = 1'b1;
        mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_up = 1'b0; bus.req_pre = 1'b0;
        bus.req_wb = 1'b0; bus.req_base = '0; bus.req_offset = '0; bus.req_store_data = '0;
        bus.req_rd = '0; bus.req_rn = '0; bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_wd", bus.mem_wd, 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_data", bus.resp_data, 32'd0);
        chk("rst resp_rd", 32'(bus.resp_rd), 32'd0);
        chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Load held in RESP by backpressure: outputs must not move.
        bp = vecs[0];
        bp.base = 32'h14; bp.offset = 12'd0; bp.rd = 4'd3;
        @(negedge clk);
        drive_req(bp);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(cyc);
        chk("bp latency", 32'(cyc), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk("bp resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp resp_data", bus.resp_data, 32'hDEADBEEF);
            chk("bp resp_rd", 32'(bus.resp_rd), 32'd3);
            chk("bp req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("bp release resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp release req_ready", 32'(bus.req_ready), 32'd1);

        // Reset pulse while a store sits in ACCESS.
        bp = vecs[1];
        bp.base = 32'h50; bp.offset = 12'd0; bp.up = 1'b1; bp.sdata = 32'h77;
        @(negedge clk);
        drive_req(bp);
        we0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstmid mem_we before", 32'(bus.mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstmid resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstmid req_ready", 32'(bus.req_ready), 32'd0);
        chk("rstmid mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstmid mem_wd", bus.mem_wd, 32'd0);
        chk("rstmid wb_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstmid no resp", 32'(bus.resp_valid), 32'd0);
        end
        chk("rstmid idle", 32'(bus.req_ready), 32'd1);
        chk("rstmid no write", 32'(we_cnt - we0), 32'd0);
        run_vec(vecs[12], "rstmid readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
